// File: rtl/trace_pkg.sv
// Shared types for the RVFI trace streamer: the captured retirement record, the
// streamer state encoding and the packet word layout.
package trace_pkg;

  localparam logic [3:0]  TRACE_SYNC = 4'hA;
  localparam int unsigned PKT_WORDS  = 6;

  typedef enum logic {IDLE, SEND} tx_state_e;

  typedef struct packed {
    logic [31:0] insn;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic        pc_err;
    logic        x0_err;
    logic [3:0]  seq;
  } rvfi_rec_t;

  // Word idx of the serialized packet; W0 is the header.
  function automatic logic [31:0] pkt_word(input rvfi_rec_t rec, input logic [2:0] idx);
    logic [31:0] w;
    case (idx)
      3'd0:    w = {TRACE_SYNC, rec.seq, rec.mem_wmask, rec.rd_addr, rec.rs1_addr,
                    rec.rs2_addr, 3'b000, rec.pc_err, rec.x0_err};
      3'd1:    w = rec.pc_rdata;
      3'd2:    w = rec.insn;
      3'd3:    w = rec.rd_wdata;
      3'd4:    w = rec.pc_wdata;
      3'd5:    w = rec.mem_addr;
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO for the trace streamer. The caller only pushes when not full or
// when the head is popped in the same cycle.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  rvfi_rec_t                i_data,
  input  logic                     i_pop,
  output rvfi_rec_t                o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  rvfi_rec_t     r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/rvfi_trace_streamer.sv
// Captures RVFI retirement records, checks PC continuity and x0 writes, and
// streams each record as a 6-word packet on a valid/ready interface.
module rvfi_trace_streamer
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rvfi_i_valid_0,
  input  logic [31:0]      rvfi_i_insn_0,
  input  logic [4:0]       rvfi_i_rs1_addr_0,
  input  logic [4:0]       rvfi_i_rs2_addr_0,
  input  logic [4:0]       rvfi_i_rd_addr_0,
  input  logic [31:0]      rvfi_i_rd_wdata_0,
  input  logic [31:0]      rvfi_i_pc_rdata_0,
  input  logic [31:0]      rvfi_i_pc_wdata_0,
  input  logic [31:0]      rvfi_i_mem_addr_0,
  input  logic [3:0]       rvfi_i_mem_wmask_0,
  output logic             tx_valid_o,
  output logic [31:0]      tx_data_o,
  output logic             tx_last_o,
  input  logic             tx_ready_i,
  input  logic             clear_i,
  output logic             overflow_o,
  output logic [CNT_W-1:0] drop_count_o,
  output logic [CNT_W-1:0] pc_err_count_o,
  output logic [CNT_W-1:0] x0_err_count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  tx_state_e        r_state, w_state_next;
  logic [2:0]       r_idx, w_idx_next;
  logic [3:0]       r_seq;
  logic             r_have_prev;
  logic [31:0]      r_prev_pc_w;
  logic [CNT_W-1:0] r_drop_cnt, r_pc_err_cnt, r_x0_err_cnt;
  logic             r_overflow;

  rvfi_rec_t   w_rec, w_head;
  logic        w_full, w_empty;
  logic [AW:0] w_count;
  logic        w_pc_err, w_x0_err, w_hs, w_pop, w_push, w_drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  assign w_pc_err = r_have_prev && (rvfi_i_pc_rdata_0 != r_prev_pc_w);
  assign w_x0_err = (rvfi_i_rd_addr_0 == 5'd0) && (rvfi_i_rd_wdata_0 != 32'd0);

  always_comb begin
    w_rec           = '0;
    w_rec.insn      = rvfi_i_insn_0;
    w_rec.rs1_addr  = rvfi_i_rs1_addr_0;
    w_rec.rs2_addr  = rvfi_i_rs2_addr_0;
    w_rec.rd_addr   = rvfi_i_rd_addr_0;
    w_rec.rd_wdata  = rvfi_i_rd_wdata_0;
    w_rec.pc_rdata  = rvfi_i_pc_rdata_0;
    w_rec.pc_wdata  = rvfi_i_pc_wdata_0;
    w_rec.mem_addr  = rvfi_i_mem_addr_0;
    w_rec.mem_wmask = rvfi_i_mem_wmask_0;
    w_rec.pc_err    = w_pc_err;
    w_rec.x0_err    = w_x0_err;
    w_rec.seq       = r_seq;
  end

  assign tx_valid_o = (r_state == SEND);
  assign tx_last_o  = tx_valid_o && (r_idx == 3'(PKT_WORDS - 1));
  assign tx_data_o  = tx_valid_o ? pkt_word(w_head, r_idx) : 32'd0;
  assign w_hs       = tx_valid_o && tx_ready_i;
  assign w_pop      = w_hs && tx_last_o;
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign w_push     = rvfi_i_valid_0 && (!w_full || w_pop);
  assign w_drop     = rvfi_i_valid_0 && !w_push;

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) w_state_next = SEND;
      end
      SEND: begin
        if (w_hs) begin
          if (tx_last_o) begin
            w_idx_next = 3'd0;
            // Another record remains after the pop: continue without a bubble.
            if ((w_count != (AW+1)'(1)) || w_push) w_state_next = SEND;
            else                                   w_state_next = IDLE;
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= 3'd0;
      r_seq       <= 4'd0;
      r_have_prev <= 1'b0;
      r_prev_pc_w <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      if (rvfi_i_valid_0) begin
        r_seq       <= r_seq + 4'd1;
        r_have_prev <= 1'b1;
        r_prev_pc_w <= rvfi_i_pc_wdata_0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt   <= '0;
      r_pc_err_cnt <= '0;
      r_x0_err_cnt <= '0;
      r_overflow   <= 1'b0;
    end else if (clear_i) begin
      r_drop_cnt   <= '0;
      r_pc_err_cnt <= '0;
      r_x0_err_cnt <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_drop_cnt   <= sat_inc(r_drop_cnt, w_drop);
      r_pc_err_cnt <= sat_inc(r_pc_err_cnt, rvfi_i_valid_0 && w_pc_err);
      r_x0_err_cnt <= sat_inc(r_x0_err_cnt, rvfi_i_valid_0 && w_x0_err);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign overflow_o     = r_overflow;
  assign drop_count_o   = r_drop_cnt;
  assign pc_err_count_o = r_pc_err_cnt;
  assign x0_err_count_o = r_x0_err_cnt;

endmodule

// File: tb/tb_rvfi_trace_streamer.sv
// Bench for rvfi_trace_streamer: a packet-queue model checked every cycle plus
// literal expectations for the directed scenarios.
module tb_rvfi_trace_streamer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_W   = 16;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             valid = 1'b0;
  logic [31:0]      insn = '0, rd_wdata = '0, pc_rdata = '0, pc_wdata = '0, mem_addr = '0;
  logic [4:0]       rs1 = '0, rs2 = '0, rd = '0;
  logic [3:0]       wmask = '0;
  logic             tx_ready = 1'b0;
  logic             clear = 1'b0;
  logic             tx_valid, tx_last, overflow;
  logic [31:0]      tx_data;
  logic [CNT_W-1:0] drop_cnt, pc_cnt, x0_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: queue of accepted packets (6 words packed, W0 at bits [31:0]).
  logic [191:0] m_q[$];
  logic         m_send;
  int           m_widx, m_seq, m_drop, m_pc, m_x0;
  logic         m_have_prev, m_ovf;
  logic [31:0]  m_prev_pc;
  logic [31:0]  log_w[$];

  always #5 clk = ~clk;

  rvfi_trace_streamer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .rvfi_i_valid_0     (valid),
    .rvfi_i_insn_0      (insn),
    .rvfi_i_rs1_addr_0  (rs1),
    .rvfi_i_rs2_addr_0  (rs2),
    .rvfi_i_rd_addr_0   (rd),
    .rvfi_i_rd_wdata_0  (rd_wdata),
    .rvfi_i_pc_rdata_0  (pc_rdata),
    .rvfi_i_pc_wdata_0  (pc_wdata),
    .rvfi_i_mem_addr_0  (mem_addr),
    .rvfi_i_mem_wmask_0 (wmask),
    .tx_valid_o         (tx_valid),
    .tx_data_o          (tx_data),
    .tx_last_o          (tx_last),
    .tx_ready_i         (tx_ready),
    .clear_i            (clear),
    .overflow_o         (overflow),
    .drop_count_o       (drop_cnt),
    .pc_err_count_o     (pc_cnt),
    .x0_err_count_o     (x0_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] get_log(input int i);
    if (i < log_w.size()) return log_w[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_send = 1'b0; m_widx = 0; m_seq = 0; m_have_prev = 1'b0; m_prev_pc = '0;
    m_drop = 0; m_pc = 0; m_x0 = 0; m_ovf = 1'b0;
  endtask

  // Checks outputs mid-cycle, then advances the model across the next edge.
  task automatic step();
    int          old;
    logic        pop, pe, xe;
    logic [31:0] hdr;
    logic [191:0] p;
    @(negedge clk);
    if (rst) begin
      model_reset();
    end else begin
      chk("tx_valid", 32'(tx_valid), 32'(m_send));
      if (m_send && m_q.size() > 0) begin
        p = m_q[0];
        chk("tx_data", tx_data, p[m_widx*32 +: 32]);
        chk("tx_last", 32'(tx_last), 32'(m_widx == 5));
        if (tx_ready) log_w.push_back(tx_data);
      end
      chk("drop_count", 32'(drop_cnt), 32'(m_drop));
      chk("pc_err_count", 32'(pc_cnt), 32'(m_pc));
      chk("x0_err_count", 32'(x0_cnt), 32'(m_x0));
      chk("overflow", 32'(overflow), 32'(m_ovf));

      old = m_q.size();
      pop = m_send && tx_ready && (m_widx == 5);
      if (pop) void'(m_q.pop_front());
      if (valid) begin
        pe  = m_have_prev && (pc_rdata != m_prev_pc);
        xe  = (rd == 0) && (rd_wdata != 0);
        hdr = 32'hA000_0000 | (32'(m_seq) << 24) | (32'(wmask) << 20) | (32'(rd) << 15)
            | (32'(rs1) << 10) | (32'(rs2) << 5) | (32'(pe) << 1) | 32'(xe);
        if (old < int'(DEPTH) || pop) m_q.push_back({mem_addr, pc_wdata, rd_wdata, insn, pc_rdata, hdr});
        else begin
          if (m_drop < CNT_MAX) m_drop++;
          m_ovf = 1'b1;
        end
        if (pe && m_pc < CNT_MAX) m_pc++;
        if (xe && m_x0 < CNT_MAX) m_x0++;
        m_have_prev = 1'b1;
        m_prev_pc   = pc_wdata;
        m_seq       = (m_seq + 1) % 16;
      end
      if (clear) begin
        m_drop = 0; m_pc = 0; m_x0 = 0; m_ovf = 1'b0;
      end
      if (!m_send) m_send = (old > 0);
      else if (tx_ready) begin
        if (m_widx == 5) begin
          m_widx = 0;
          m_send = (m_q.size() > 0);
        end else m_widx++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_rec(input logic [4:0] r_d, input logic [4:0] r_s1, input logic [4:0] r_s2,
                         input logic [31:0] wd, input logic [31:0] ins, input logic [31:0] pcr,
                         input logic [31:0] pcw, input logic [31:0] ma, input logic [3:0] wm);
    rd = r_d; rs1 = r_s1; rs2 = r_s2; rd_wdata = wd; insn = ins;
    pc_rdata = pcr; pc_wdata = pcw; mem_addr = ma; wmask = wm;
  endtask

  task automatic pulse(input logic [4:0] r_d, input logic [4:0] r_s1, input logic [4:0] r_s2,
                       input logic [31:0] wd, input logic [31:0] ins, input logic [31:0] pcr,
                       input logic [31:0] pcw, input logic [31:0] ma, input logic [3:0] wm);
    set_rec(r_d, r_s1, r_s2, wd, ins, pcr, pcw, ma, wm);
    valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  // Called just after a rising edge; reset lands mid-cycle.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_last", 32'(tx_last), 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int base, n;
    model_reset();
    @(posedge clk); #1;
    step(); step();
    rst = 1'b0;
    chk("init_valid", 32'(tx_valid), 32'd0);
    chk("init_drop", 32'(drop_cnt), 32'd0);
    chk("init_ovf", 32'(overflow), 32'd0);

    // Single record and first-packet latency.
    tx_ready = 1'b1;
    base = log_w.size();
    pulse(5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 32'h100, 32'h104, 32'h0, 4'h0);
    chk("lat_idle", 32'(tx_valid), 32'd0);
    step();
    chk("lat_send", 32'(tx_valid), 32'd1);
    repeat (8) step();
    chk("p1_len", 32'(log_w.size() - base), 32'd6);
    chk("p1_w0", get_log(base + 0), 32'hA000_8000);
    chk("p1_w1", get_log(base + 1), 32'h0000_0100);
    chk("p1_w2", get_log(base + 2), 32'h0050_0093);
    chk("p1_w3", get_log(base + 3), 32'h0000_0005);
    chk("p1_w4", get_log(base + 4), 32'h0000_0104);
    chk("p1_w5", get_log(base + 5), 32'h0000_0000);

    // PC continuity break on the second of two back-to-back records.
    base = log_w.size();
    pulse(5'd3, 5'd1, 5'd2, 32'h11, 32'h0020_81B3, 32'h104, 32'h108, 32'h0, 4'h0);
    pulse(5'd2, 5'd1, 5'd0, 32'h22, 32'h0010_8113, 32'h200, 32'h204, 32'h0, 4'h0);
    repeat (20) step();
    chk("pcA_hdr", get_log(base + 0), 32'hA101_8440);
    chk("pcB_hdr", get_log(base + 6), 32'hA201_0402);
    chk("pc_cnt1", 32'(pc_cnt), 32'd1);

    // x0 writes: non-zero flags, zero does not.
    base = log_w.size();
    pulse(5'd0, 5'd0, 5'd0, 32'h7, 32'h0070_0013, 32'h204, 32'h208, 32'h0, 4'h0);
    pulse(5'd0, 5'd0, 5'd0, 32'h0, 32'h0000_0013, 32'h208, 32'h20C, 32'h0, 4'h0);
    repeat (20) step();
    chk("x0C_hdr", get_log(base + 0), 32'hA300_0001);
    chk("x0D_hdr", get_log(base + 6), 32'hA400_0000);
    chk("x0_cnt1", 32'(x0_cnt), 32'd1);

    // Overflow with the sink stalled, then back-to-back drain and clear.
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      pulse(5'(i + 1), 5'd0, 5'd0, 32'(i), 32'h13, 32'h300 + 32'(4 * i), 32'h304 + 32'(4 * i),
            32'h1000 + 32'(i), 4'hF);
    step();
    chk("ovf_drop", 32'(drop_cnt), 32'd2);
    chk("ovf_flag", 32'(overflow), 32'd1);
    base = log_w.size();
    tx_ready = 1'b1;
    repeat (30) step();
    chk("ovf_len", 32'(log_w.size() - base), 32'd24);
    for (int k = 0; k < 4; k++)
      chk("ovf_seq", (get_log(base + 6 * k) >> 24) & 32'hF, 32'(k));
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_drop", 32'(drop_cnt), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Random backpressure with interleaved records.
    for (int i = 0; i < 100; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      if (i % 3 == 0)
        set_rec(5'(i % 7), 5'(i % 5), 5'(i % 3), $urandom, $urandom, 32'h400 + 32'(4 * i),
                (i % 9 == 0) ? 32'h800 : 32'h404 + 32'(4 * i), $urandom, 4'(i));
      valid = (i % 3 == 0);
      step();
    end
    valid = 1'b0;
    tx_ready = 1'b1;
    repeat (40) step();
    chk("bp_idle", 32'(tx_valid), 32'd0);

    // Full FIFO plus a push in the pop cycle is accepted.
    clear = 1'b1;
    step();
    clear = 1'b0;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      pulse(5'd1, 5'd2, 5'd3, 32'(i), 32'h33, 32'h500 + 32'(4 * i), 32'h504 + 32'(4 * i),
            32'h0, 4'h1);
    tx_ready = 1'b1;
    n = 0;
    while (!tx_last && n < 10) begin
      step();
      n++;
    end
    chk("full_last", 32'(tx_last), 32'd1);
    pulse(5'd1, 5'd2, 5'd3, 32'h99, 32'h33, 32'h510, 32'h514, 32'h0, 4'h1);
    chk("full_nodrop", 32'(drop_cnt), 32'd0);
    repeat (40) step();
    chk("full_idle", 32'(tx_valid), 32'd0);

    // Reset in the middle of a packet with two more records queued.
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      pulse(5'd4, 5'd0, 5'd0, 32'h70 + 32'(i), 32'h13, 32'h600 + 32'(4 * i), 32'h604 + 32'(4 * i),
            32'h0, 4'h0);
    tx_ready = 1'b1;
    repeat (3) step();
    chk("rst_w3", tx_data, 32'h70);
    do_reset();
    base = log_w.size();
    pulse(5'd1, 5'd0, 5'd0, 32'd1, 32'h13, 32'h999, 32'h99D, 32'h0, 4'h0);
    repeat (12) step();
    chk("post_len", 32'(log_w.size() - base), 32'd6);
    chk("post_hdr", get_log(base), 32'hA000_8000);
    chk("post_pc", 32'(pc_cnt), 32'd0);
    chk("post_idle", 32'(tx_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
